// File: rtl/adc088s102_emu.sv
// ---------------------------------------------------------------------------
// adc088s102_emu
//
// Emulates the serial side of an ADC088S102 8-channel converter. The SPI
// master drives sck/cs_n/din asynchronously to clk. Each 16-clock frame
// returns {4'b0, ch_data[cur_addr], 4'b0} on dout, MSB first, and captures
// the channel address for the next frame from din (rising edges 3..5).
//
// Parameters
//   SYNC_STAGES  synchronizer depth for sck, cs_n, din (2..4)
//
// Ports
//   clk         system clock, all logic on rising edge
//   reset       asynchronous active-high reset
//   sck         SPI clock from the master (idles high)
//   cs_n        active-low frame select
//   din         master-to-converter serial data (channel address)
//   ch_data     eight 8-bit channel values, channel k at [8k+7:8k]
//   dout        converter-to-master serial data
//   dout_oe     high while dout is driven (frame selected)
//   cur_addr    channel to be sent in the next frame
//   frame_done  one-clk pulse when a full 16-bit frame completes
//   err_cnt     saturating count of aborts and overrun sck edges
//
// Build option
//   ADC_EMU_ERR_COUNT_EN  when defined, err_cnt counts protocol errors;
//                         when undefined, the error logic is omitted and
//                         err_cnt is tied to zero.
// ---------------------------------------------------------------------------
module adc088s102_emu #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sck,
    input  logic        cs_n,
    input  logic        din,
    input  logic [63:0] ch_data,
    output logic        dout,
    output logic        dout_oe,
    output logic [2:0]  cur_addr,
    output logic        frame_done,
    output logic [7:0]  err_cnt
);

    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Input synchronizers and edge-detect history
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] din_sync_q;
    logic [SYNC_STAGES-1:0] flush_q;
    logic                   sck_prev_q;
    logic                   cs_prev_q;
    logic                   cs_armed_q;

    logic sck_s, cs_s, din_s, sync_valid;
    logic sck_rise, sck_fall, cs_rise, cs_fall, cs_edge;

    // Decoded control strobes
    logic load_frame;
    logic end_frame;
    logic rise_act;
    logic fall_act;

    // Datapath registers
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [2:0]            addr_cap_q, addr_cap_d;
    logic [2:0]            cur_addr_q, cur_addr_d;
    logic                  frame_done_q, frame_done_d;
    logic [DATA_W-1:0]     ch_sel;

    assign sck_s      = sck_sync_q[SYNC_STAGES-1];
    assign cs_s       = cs_sync_q[SYNC_STAGES-1];
    assign din_s      = din_sync_q[SYNC_STAGES-1];
    assign sync_valid = flush_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync_q <= '1;
            cs_sync_q  <= '1;
            din_sync_q <= '0;
            flush_q    <= '0;
            sck_prev_q <= 1'b1;
            cs_prev_q  <= 1'b1;
            cs_armed_q <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], din};
            flush_q    <= {flush_q[SYNC_STAGES-2:0], 1'b1};
            sck_prev_q <= sck_s;
            cs_prev_q  <= cs_s;
            // The synchronizer still holds reset values until flush_q fills;
            // only a genuinely observed high cs_n arms frame start, so a
            // cs_n held low through reset cannot fake a falling edge.
            if (sync_valid && cs_s) begin
                cs_armed_q <= 1'b1;
            end
        end
    end

    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q & cs_armed_q;
    assign cs_edge  = cs_rise | cs_fall;

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state (cs_n edges pre-empt any sck edge in the same clk)
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (cs_fall) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (cs_rise) begin
                    state_d = S_IDLE;
                end else if (!cs_edge && sck_rise && bit_cnt_q == 5'(FRAME_BITS - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (cs_rise) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs and control strobes
    always_comb begin
        dout_oe    = (state_q != S_IDLE);
        load_frame = (state_q == S_IDLE) && cs_fall;
        end_frame  = (state_q != S_IDLE) && cs_rise;
        rise_act   = (state_q == S_ACTIVE) && sck_rise && !cs_edge;
        // The very first sck fall (before any rise) is the master leaving
        // idle; it must not consume the leading zero.
        fall_act   = (state_q == S_ACTIVE) && sck_fall && !cs_edge && (bit_cnt_q != 5'd0);
    end

    assign ch_sel = ch_data[{cur_addr_q, 3'b000} +: DATA_W];

    // Datapath next state
    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        addr_cap_d   = addr_cap_q;
        cur_addr_d   = cur_addr_q;
        frame_done_d = 1'b0;
        if (load_frame) begin
            bit_cnt_d  = 5'd0;
            shift_d    = {4'b0000, ch_sel, 4'b0000};
            addr_cap_d = 3'b000;
        end else if (end_frame) begin
            bit_cnt_d = 5'd0;
            shift_d   = '0;
        end else if (rise_act) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q >= 5'd2 && bit_cnt_q <= 5'd4) begin
                addr_cap_d = {addr_cap_q[1:0], din_s};
            end
            if (bit_cnt_q == 5'(FRAME_BITS - 1)) begin
                cur_addr_d   = addr_cap_q;
                frame_done_d = 1'b1;
                // DONE drives zero regardless of later sck activity.
                shift_d      = '0;
            end
        end else if (fall_act) begin
            shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt_q    <= 5'd0;
            shift_q      <= '0;
            addr_cap_q   <= 3'b000;
            cur_addr_q   <= 3'b000;
            frame_done_q <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            addr_cap_q   <= addr_cap_d;
            cur_addr_q   <= cur_addr_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign dout       = shift_q[FRAME_BITS-1];
    assign cur_addr   = cur_addr_q;
    assign frame_done = frame_done_q;

`ifdef ADC_EMU_ERR_COUNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       err_event;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Abort and overrun are mutually exclusive in one clk: an overrun needs
    // an sck edge that survived cs_n priority, an abort needs a cs_n edge.
    always_comb begin
        err_event = ((state_q == S_ACTIVE) && cs_rise) ||
                    ((state_q == S_DONE) && sck_rise && !cs_edge);
        err_cnt_d = err_event ? sat_inc(err_cnt_q) : err_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_adc088s102_emu.sv
// ---------------------------------------------------------------------------
// tb_adc088s102_emu
//
// Drives SPI frames from a behavioural master, records the dout bit seen
// just before each sck rising edge, and compares against a frame-level
// model: stream = {4'b0, ch_data[model_addr] at frame start, 4'b0}.
// ---------------------------------------------------------------------------
module tb_adc088s102_emu;

    localparam int SYNC = 2;
    localparam int HMIN = SYNC + 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        sck;
    logic        cs_n;
    logic        din;
    logic [63:0] ch_data;
    logic        dout;
    logic        dout_oe;
    logic [2:0]  cur_addr;
    logic        frame_done;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad   = 0;
    int fd_cnt = 0;

    // Reference model state
    int m_addr = 0;
    int m_err  = 0;

    adc088s102_emu #(.SYNC_STAGES(SYNC)) dut (
        .clk        (clk),
        .reset      (reset),
        .sck        (sck),
        .cs_n       (cs_n),
        .din        (din),
        .ch_data    (ch_data),
        .dout       (dout),
        .dout_oe    (dout_oe),
        .cur_addr   (cur_addr),
        .frame_done (frame_done),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt = fd_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [63:0] ch;
        logic [2:0]  addr;
        int          nrise;
        logic [15:0] exp_stream;
        int          exp_fd;
        logic [2:0]  exp_addr;
        int          exp_err_on;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic int exp_err(input int e);
`ifdef ADC_EMU_ERR_COUNT_EN
        return e;
`else
        return 0 * e;
`endif
    endfunction

    function automatic logic [15:0] model_stream(input logic [63:0] ch, input int a);
        logic [63:0] t;
        t = ch >> (8 * a);
        return {4'h0, t[7:0], 4'h0};
    endfunction

    // Frame-level model update after a frame of nrise sck rising edges.
    task automatic model_frame(input logic [2:0] a, input int nrise);
        int inc;
        if (nrise >= 16) begin
            m_addr = int'(a);
            inc = nrise - 16;
        end else begin
            inc = 1;
        end
        m_err = (m_err + inc > 255) ? 255 : m_err + inc;
    endtask

    task automatic do_frame(input logic [2:0] a, input int nrise, input int half,
                            input int chg_at, input logic [63:0] chg_val,
                            output logic [15:0] stream, output logic ovr_or);
        stream = '0;
        ovr_or = 1'b0;
        cs_n = 1'b0;
        repeat (SYNC) @(negedge clk);
        check("oe_before_latency", 32'(dout_oe), 32'd0);
        @(negedge clk);
        check("oe_at_latency", 32'(dout_oe), 32'd1);
        repeat (half - SYNC - 1) @(negedge clk);
        for (int k = 0; k < nrise; k++) begin
            sck = 1'b0;
            case (k)
                2: din = a[2];
                3: din = a[1];
                4: din = a[0];
                default: din = 1'($urandom_range(0, 1));
            endcase
            if (k == chg_at) ch_data = chg_val;
            repeat (half) @(negedge clk);
            if (k < 16) stream = {stream[14:0], dout};
            else ovr_or = ovr_or | dout;
            sck = 1'b1;
            repeat (half) @(negedge clk);
        end
        cs_n = 1'b1;
        repeat (half) @(negedge clk);
        check("oe_after_frame", 32'(dout_oe), 32'd0);
        check("dout_after_frame", 32'(dout), 32'd0);
    endtask

    vec_t vecs[5];

    initial begin
        logic [15:0] stream;
        logic        ovr;
        logic [15:0] exp_s;
        int          fd0;
        int          n;

        vecs[0] = '{64'h0000_0000_0000_00A5, 3'd3, 16, 16'h0A50, 1, 3'd3, 0};
        vecs[1] = '{64'h0000_0000_3C00_0000, 3'd5, 16, 16'h03C0, 1, 3'd5, 0};
        vecs[2] = '{64'h0000_8100_0000_0000, 3'd1,  7, 16'h0810, 0, 3'd5, 1};
        vecs[3] = '{64'h0000_8100_0000_0000, 3'd2, 18, 16'h0810, 1, 3'd2, 3};
        vecs[4] = '{64'hFFFF_FFFF_FF5A_FFFF, 3'd7, 16, 16'h05A0, 1, 3'd7, 3};

        reset   = 1'b1;
        sck     = 1'b1;
        cs_n    = 1'b1;
        din     = 1'b0;
        ch_data = '0;
        repeat (4) @(negedge clk);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_oe", 32'(dout_oe), 32'd0);
        check("rst_cur_addr", 32'(cur_addr), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_err", 32'(err_cnt), 32'd0);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        // Directed table
        for (int i = 0; i < 5; i++) begin
            ch_data = vecs[i].ch;
            fd0 = fd_cnt;
            do_frame(vecs[i].addr, vecs[i].nrise, 6, -1, '0, stream, ovr);
            n = (vecs[i].nrise < 16) ? vecs[i].nrise : 16;
            check($sformatf("tbl%0d_stream", i), 32'(stream), 32'(vecs[i].exp_stream >> (16 - n)));
            check($sformatf("tbl%0d_overrun_dout", i), 32'(ovr), 32'd0);
            check($sformatf("tbl%0d_frame_done", i), 32'(fd_cnt - fd0), 32'(vecs[i].exp_fd));
            check($sformatf("tbl%0d_cur_addr", i), 32'(cur_addr), 32'(vecs[i].exp_addr));
            check($sformatf("tbl%0d_err", i), 32'(err_cnt), 32'(exp_err(vecs[i].exp_err_on)));
            model_frame(vecs[i].addr, vecs[i].nrise);
        end

        // ch_data changes mid-frame: frame keeps the value seen at cs_n fall
        ch_data = 64'hFF00_0000_0000_0000;
        fd0 = fd_cnt;
        do_frame(3'd0, 16, 6, 3, 64'h0, stream, ovr);
        check("midchg_stream", 32'(stream), 32'h0FF0);
        check("midchg_frame_done", 32'(fd_cnt - fd0), 32'd1);
        check("midchg_cur_addr", 32'(cur_addr), 32'd0);
        model_frame(3'd0, 16);

        // Reset in the middle of a frame, released with cs_n still low
        ch_data = 64'h0123_4567_89AB_CDEF;
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            sck = 1'b0;
            repeat (6) @(negedge clk);
            sck = 1'b1;
            repeat (6) @(negedge clk);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_addr = 0;
        m_err  = 0;
        repeat (12) @(negedge clk);
        check("rstmid_oe", 32'(dout_oe), 32'd0);
        check("rstmid_dout", 32'(dout), 32'd0);
        check("rstmid_err", 32'(err_cnt), 32'd0);
        fd0 = fd_cnt;
        for (int k = 0; k < 16; k++) begin
            sck = 1'b0;
            repeat (5) @(negedge clk);
            sck = 1'b1;
            repeat (5) @(negedge clk);
        end
        check("rstmid_oe_sck", 32'(dout_oe), 32'd0);
        check("rstmid_no_frame", 32'(fd_cnt - fd0), 32'd0);
        check("rstmid_err_sck", 32'(err_cnt), 32'd0);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        fd0 = fd_cnt;
        do_frame(3'd6, 16, 5, -1, '0, stream, ovr);
        check("rstmid_next_stream", 32'(stream), 32'(model_stream(ch_data, m_addr)));
        check("rstmid_next_fd", 32'(fd_cnt - fd0), 32'd1);
        check("rstmid_next_err", 32'(err_cnt), 32'd0);
        model_frame(3'd6, 16);
        check("rstmid_next_addr", 32'(cur_addr), 32'(m_addr));

        // Randomized frames against the model
        for (int i = 0; i < 24; i++) begin
            logic [2:0]  a;
            logic [63:0] newv;
            int          nr;
            int          r;
            int          half;
            int          chg;
            ch_data = {$urandom, $urandom};
            newv    = {$urandom, $urandom};
            a       = 3'($urandom_range(0, 7));
            r       = $urandom_range(0, 9);
            nr      = (r < 6) ? 16 : (r < 8) ? $urandom_range(5, 15) : $urandom_range(17, 19);
            half    = $urandom_range(HMIN, HMIN + 3);
            chg     = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 10) : -1;
            exp_s   = model_stream(ch_data, m_addr);
            n       = (nr < 16) ? nr : 16;
            fd0     = fd_cnt;
            do_frame(a, nr, half, chg, newv, stream, ovr);
            model_frame(a, nr);
            check($sformatf("rnd%0d_stream", i), 32'(stream), 32'(exp_s >> (16 - n)));
            check($sformatf("rnd%0d_overrun_dout", i), 32'(ovr), 32'd0);
            check($sformatf("rnd%0d_frame_done", i), 32'(fd_cnt - fd0), 32'((nr >= 16) ? 1 : 0));
            check($sformatf("rnd%0d_cur_addr", i), 32'(cur_addr), 32'(m_addr));
            check($sformatf("rnd%0d_err", i), 32'(err_cnt), 32'(exp_err(m_err)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc088s102_emu.md
ADC088S102_EMU -- requirements
Module: adc088s102_emu

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth for sck, cs_n and din (legal 2..4).
REQ-002 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port sck, input, 1, SPI clock from the ADC master; idles high.
REQ-005 SHALL have port cs_n, input, 1, active-low frame select from the master.
REQ-006 SHALL have port din, input, 1, master-to-converter serial data (channel address).
REQ-007 SHALL have port ch_data, input, 64, eight 8-bit channel values; channel k at bits [8k+7:8k].
REQ-008 SHALL have port dout, output, 1, converter-to-master serial data.
REQ-009 SHALL have port dout_oe, output, 1, high while dout is driven (cs_n low); external tri-state control.
REQ-010 SHALL have port cur_addr, output, 3, channel to be sent in the next frame.
REQ-011 SHALL have port frame_done, output, 1, one-clk pulse on completion of a full 16-bit frame.
REQ-012 SHALL have port err_cnt, output, 8, saturating protocol-error count (see Configuration).

Function
REQ-013 SHALL synchronize sck, cs_n, din through SYNC_STAGES flops, then detect edges on the synchronized copies; pin-to-dout latency SYNC_STAGES+1 clk cycles.
REQ-014 SHALL operate correctly when each sck high and low phase lasts at least SYNC_STAGES+2 clk cycles.
REQ-015 SHALL implement states IDLE, ACTIVE, DONE.
REQ-016 IDLE -> ACTIVE on cs_n falling edge: bit_cnt=0, 16-bit shift reg loaded with {4'b0, ch_data[cur_addr], 4'b0}, addr capture reg cleared, dout_oe=1.
REQ-017 In ACTIVE, each sck rising edge SHALL increment bit_cnt; din sampled at bit_cnt 2,3,4 (before increment) shifts MSB-first into addr capture reg.
REQ-018 In ACTIVE, each sck falling edge occurring after at least one rising edge SHALL shift the register left one bit, zero-filling; dout always equals shift reg MSB.
REQ-019 Resulting dout: 4 leading zeros, 8 data bits MSB first (bits valid after falling edges 4..11), 4 trailing zeros.
REQ-020 On 16th sck rising edge: cur_addr <= addr capture reg, frame_done pulses for one clk, state -> DONE.
REQ-021 In DONE, further sck edges SHALL be ignored, dout held 0; overrun rising edge counts one error.
REQ-022 ACTIVE or DONE -> IDLE on cs_n rising edge; dout_oe=0, dout=0.
REQ-023 cs_n rising edge in ACTIVE (bit_cnt<16) is an abort: cur_addr unchanged, no frame_done, one error counted.
REQ-024 When a cs_n edge and an sck edge are detected in the same clk, the cs_n edge SHALL take priority and the sck edge is discarded.
REQ-025 ch_data SHALL be sampled only at cs_n falling edge; later changes do not affect the current frame.
REQ-026 sck edges in IDLE SHALL be ignored.

Reset
REQ-027 On reset: state IDLE, synchronizer flops for sck and cs_n set to 1, din flops 0, bit_cnt=0, shift reg 0.
REQ-028 Reset values: dout=0, dout_oe=0, cur_addr=0, frame_done=0, err_cnt=0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame without counting an error; after release a new frame starts only on a fresh cs_n falling edge.

Configuration
REQ-030 Macro ADC_EMU_ERR_COUNT_EN defined: err_cnt increments (saturating at 255) per abort (REQ-023) and per overrun edge (REQ-021), at most one increment per clk.
REQ-031 Macro ADC_EMU_ERR_COUNT_EN undefined: error logic omitted, err_cnt tied to 0; all other behaviour identical.

Verification
REQ-032 Reset, ch_data channel0=8'hA5, one 16-sck frame with din address 3'b011 -> dout stream 0000_1010_0101_0000, frame_done one pulse, cur_addr=3.
REQ-033 Second frame after REQ-032 with channel3=8'h3C -> dout 0000_0011_1100_0000.
REQ-034 cs_n raised after 7 sck rising edges -> cur_addr unchanged, no frame_done, dout_oe=0, err_cnt=1 (macro on) / 0 (macro off).
REQ-035 18 sck rising edges in one frame -> frame_done once, dout 0 after bit 16, err_cnt=2 (macro on).
REQ-036 ch_data changed from 8'hFF to 8'h00 mid-frame -> dout still carries 8'hFF.
REQ-037 Reset asserted at bit 8 of a frame, released with cs_n low -> dout_oe=0, no frame until cs_n high then low; err_cnt=0.
